fetch_aligner: RTL and testbench
================================

# fetch_aligner

Instruction fetch front end. It produces the 32-bit instruction stream consumed by `control_unit`: word-aligned reads from instruction memory are realigned into whole RV32/RVC instructions. Compressed instructions are passed through unexpanded, zero-extended in `[31:16]`, so the decoder's expander sees them on `[15:0]`. It sits between the instruction-memory port and the decode stage and handles PC redirects from branch/jump resolution.

## Interface
Parameters:
- `XLEN`, 32, address/PC width.
- `RESET_PC`, 0, first fetch PC; bit 0 must be 0.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  memory read request.
- `imem_addr`  out  XLEN  word address; bits `[1:0]` are always 0.
- `imem_ack`  in  1  read completes this cycle.
- `imem_rdata`  in  32  read data; valid only when `imem_ack` is high.
- `redirect`  in  1  flush and restart at `redirect_pc`.
- `redirect_pc`  in  XLEN  new PC; bit 0 is ignored.
- `instr_valid`  out  1  `instr_out` holds a complete instruction.
- `instr_ready`  in  1  decode accepts `instr_out`.
- `instr_out`  out  32  instruction: full 32-bit, or `{16'h0, c}` for RVC.
- `instr_pc`  out  XLEN  PC of `instr_out`.

## Operation
- **Halfword buffer.**
  - 3 halfword slots (48 bits) plus a count (0–3).
  - Slot 0 is the head; its PC is `head_pc`.
- **Instruction length.**
  - Head is compressed iff `head[1:0] != 2'b11`.
- **Output valid.**
  - `instr_valid` = (count ≥ 1 and head is compressed) or count ≥ 2.
- **Output content.**
  - Compressed: `instr_out = {16'h0, slot0}`.
  - Full: `instr_out = {slot1, slot0}`.
- **Consume** on `instr_valid & instr_ready`:
  - shift out 1 halfword (compressed) or 2 (full);
  - `head_pc` += 2 or 4.
- **Append** on `imem_ack`:
  - push `rdata[15:0]`, then `rdata[31:16]`, after the shift;
  - if `skip_low` is set, push only `rdata[31:16]` and clear `skip_low`;
  - `fetch_addr` += 4.
- **Simultaneous consume and ack.** Shift first, then append. Count never exceeds 3.
- **FSM states:**
  - `IDLE`: `imem_req=0`.
  - `REQ`: `imem_req=1` with `imem_addr=fetch_addr`. Address is held stable until `imem_ack`.
  - `FLUSH`: `imem_req=1` on a stale address; wait for its ack and discard the data.
- **Transitions:**
  - `IDLE`→`REQ` when count ≤ 1 after this cycle's consume (room for 2 halfwords).
  - `REQ`→`REQ` on ack if count-after-update ≤ 1, else `IDLE`.
  - `REQ`→`FLUSH` on `redirect` without ack.
  - `FLUSH`→`REQ` on ack.
- **Redirect** (priority over consume and append in the same cycle):
  - count ← 0;
  - `head_pc` ← `{redirect_pc[XLEN-1:1], 1'b0}`;
  - `fetch_addr` ← `{redirect_pc[XLEN-1:2], 2'b00}`;
  - `skip_low` ← `redirect_pc[1]`.
- **Redirect and ack in the same cycle.** Discard the data and go to `REQ` at the new `fetch_addr`.
- **Redirect while in `FLUSH`.** Update the target and remain in `FLUSH`.
- **Reset values:**
  - `imem_req=0`, `imem_addr=RESET_PC & ~3`;
  - `instr_valid=0`, `instr_out=0`, `instr_pc=RESET_PC`;
  - count=0, `skip_low=RESET_PC[1]`, state `IDLE`.
- **Reset mid-request.** Any in-flight `imem_ack` is ignored; the memory side must also be reset.

## Timing
- **Output path.** `instr_valid`, `instr_out` and `instr_pc` are combinational from registers only. No path from `instr_ready`.
- **Stability.** Once `instr_valid` rises, `instr_out` and `instr_pc` hold until consumed or redirected.
- **Request stability.** `imem_req` and `imem_addr` do not change while a request is pending; `redirect` does not drop `imem_req`.
- **Latencies:**
  - reset release at cycle 0 → `imem_req` at cycle 1;
  - `imem_ack` at cycle N → `instr_valid` at N+1;
  - `redirect` at N (no pending request) → `imem_req` at N+1 with the new address.
- **Throughput.** One instruction per cycle with a zero-wait memory.
  - Back-to-back acks are allowed; `imem_req` stays high across ack while a new fetch is needed.

## Structure
- **Shared package `fetch_pkg`:**
  - `fetch_state_e` (`IDLE`, `REQ`, `FLUSH`);
  - `RVC_FULL_LEN = 2'b11`.
- **Sub-module `halfword_buffer`:** 3-slot shift/append storage and count.
  - Inputs: shift amount (0/1/2), push amount (0/1/2), flush.
  - Outputs: `slot0`, `slot1`, count.
- **FSM, PC tracking and redirect logic** live in `fetch_aligner`.

## Test plan
- **Reset then straight-line 32-bit code.**
  - Stimulus: zero-wait memory returns `0x00100093`, `0x00200113`; `instr_ready=1`.
  - Required: outputs `0x00100093` @PC 0, then `0x00200113` @PC 4; first `instr_valid` 2 cycles after reset release.
- **Mixed RVC/32-bit straddling a word boundary.**
  - Stimulus: word0 `0x00934505`, word1 `0x00000100`.
  - Required: `0x00004505` @0, then `0x01000093` @2.
- **Redirect to a halfword address.**
  - Stimulus: `redirect_pc=0x102`; word at 0x100 is `0x4585AAAA`.
  - Required: `imem_addr=0x100`, low half discarded, `instr_out=0x00004585` @`0x102`.
- **Redirect while a request is pending.**
  - Stimulus: memory acks 3 cycles later.
  - Required: stale data is never presented; the next request is to the new aligned address.
- **Backpressure.**
  - Stimulus: `instr_ready=0` for 5 cycles.
  - Required: output is stable, count ≤ 3, `imem_req` drops to 0 once the buffer holds ≥ 2 halfwords; no data is lost when ready resumes.
- **Consume, ack and redirect in one cycle.**
  - Required: redirect wins; buffer is empty next cycle, `instr_pc` equals the redirect target, and a new request is issued at the new address.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   fetch_state_e : request FSM states (IDLE, REQ, FLUSH)
//   RVC_FULL_LEN  : low two bits that mark a full-length (32-bit) instruction
//   HW_SLOTS      : depth of the halfword realignment buffer
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   localparam logic [1:0] RVC_FULL_LEN = 2'b11;
   localparam int unsigned HW_SLOTS    = 3;

endpackage

// File: rtl/halfword_buffer.sv
// halfword_buffer: three-slot halfword queue used to realign fetched words
// into whole instructions. Each cycle the head is first shifted out by
// shift_amt halfwords, then up to two halfwords are appended behind the
// survivors. flush empties the queue and overrides shift/push.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empty the buffer
//   shift_amt    : halfwords consumed from the head (0/1/2)
//   push_amt     : halfwords appended (0/1/2); 1 appends push_data[31:16]
//   push_data    : fetched word; 2 appends [15:0] then [31:16]
//   slot0, slot1 : head halfword and the one behind it
//   count        : number of valid halfwords (0-3)
module halfword_buffer
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [1:0]  shift_amt,
   input  logic [1:0]  push_amt,
   input  logic [31:0] push_data,
   output logic [15:0] slot0,
   output logic [15:0] slot1,
   output logic [1:0]  count
);

   logic [16*HW_SLOTS-1:0] buf_reg;
   logic [16*HW_SLOTS-1:0] buf_next;
   logic [1:0]             count_reg;
   logic [2:0]             count_next;
   logic [1:0]             kept;
   logic [15:0]            push_first;
   // Zero padding lets a slot read "two beyond the tail" without a range check.
   logic [16*HW_SLOTS+31:0] ext;

   assign kept       = count_reg - shift_amt;
   assign count_next = {1'b0, kept} + {1'b0, push_amt};
   assign push_first = (push_amt == 2'd1) ? push_data[31:16] : push_data[15:0];
   assign ext        = {32'h0, buf_reg};

   genvar gi;
   generate
      for (gi = 0; gi < HW_SLOTS; gi++) begin : gen_slot
         logic [2:0]  src;
         logic [15:0] slot_nxt;

         assign src = 3'(gi) + {1'b0, shift_amt};

         always_comb begin
            slot_nxt = ext[16*src +: 16];
            // Appended halfwords land right behind whatever survived the shift.
            if (push_amt != 2'd0 && 3'(gi) == {1'b0, kept})
               slot_nxt = push_first;
            if (push_amt == 2'd2 && 3'(gi) == {1'b0, kept} + 3'd1)
               slot_nxt = push_data[31:16];
         end

         assign buf_next[16*gi +: 16] = slot_nxt;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         buf_reg   <= '0;
         count_reg <= 2'd0;
      end else begin
         buf_reg   <= buf_next;
         count_reg <= count_next[1:0];
      end
   end

   assign slot0 = buf_reg[15:0];
   assign slot1 = buf_reg[31:16];
   assign count = count_reg;

endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: instruction fetch front end. Issues word-aligned reads to
// instruction memory and realigns the returned halfwords into whole RV32 /
// RVC instructions for decode. Compressed instructions are presented
// zero-extended in [31:16]. Redirects flush the buffer and restart fetch;
// a read already in flight is waited out in FLUSH and its data dropped.
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req/addr            : memory read request, word address
//   imem_ack/rdata           : read completion and data
//   redirect/redirect_pc     : restart fetch at a new PC
//   instr_valid/ready/out/pc : instruction handshake toward decode
module fetch_aligner
   import fetch_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] instr_pc
);

   fetch_state_e    state_reg, state_next;
   logic [XLEN-1:0] head_pc_reg;
   logic [XLEN-1:0] fetch_addr_reg;
   logic [XLEN-1:0] flush_addr_reg;
   logic            skip_low_reg;

   logic [15:0] slot0, slot1;
   logic [1:0]  count;
   logic        head_compressed;
   logic        consume;
   logic        ack_take;
   logic [1:0]  shift_amt;
   logic [1:0]  push_amt;
   logic [1:0]  count_kept;
   logic [2:0]  count_after;

   halfword_buffer u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .shift_amt (shift_amt),
      .push_amt  (push_amt),
      .push_data (imem_rdata),
      .slot0     (slot0),
      .slot1     (slot1),
      .count     (count)
   );

   // Output side depends on registered state only.
   assign head_compressed = (slot0[1:0] != RVC_FULL_LEN);
   assign instr_valid     = (count != 2'd0 && head_compressed) || (count >= 2'd2);
   assign instr_out       = head_compressed ? {16'h0, slot0} : {slot1, slot0};
   assign instr_pc        = head_pc_reg;

   assign consume   = instr_valid && instr_ready;
   assign shift_amt = consume ? (head_compressed ? 2'd1 : 2'd2) : 2'd0;
   // Data is accepted only for a live request; a redirect in the same cycle
   // makes it stale.
   assign ack_take  = imem_ack && (state_reg == REQ) && !redirect;
   assign push_amt  = ack_take ? (skip_low_reg ? 2'd1 : 2'd2) : 2'd0;

   assign count_kept  = count - shift_amt;
   assign count_after = {1'b0, count_kept} + {1'b0, push_amt};

   assign imem_req  = (state_reg != IDLE);
   // In FLUSH the stale address stays on the bus until its ack arrives.
   assign imem_addr = (state_reg == FLUSH) ? flush_addr_reg : fetch_addr_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (redirect || count_kept <= 2'd1)
               state_next = REQ;
         end
         REQ: begin
            if (redirect)
               state_next = imem_ack ? REQ : FLUSH;
            else if (imem_ack)
               state_next = (count_after <= 3'd1) ? REQ : IDLE;
         end
         FLUSH: begin
            if (imem_ack)
               state_next = REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         head_pc_reg    <= RESET_PC;
         fetch_addr_reg <= {RESET_PC[XLEN-1:2], 2'b00};
         flush_addr_reg <= {RESET_PC[XLEN-1:2], 2'b00};
         skip_low_reg   <= RESET_PC[1];
      end else begin
         state_reg <= state_next;
         if (redirect) begin
            head_pc_reg    <= {redirect_pc[XLEN-1:1], 1'b0};
            fetch_addr_reg <= {redirect_pc[XLEN-1:2], 2'b00};
            skip_low_reg   <= redirect_pc[1];
            // Remember the address of the read we are abandoning.
            if (state_reg == REQ && !imem_ack)
               flush_addr_reg <= fetch_addr_reg;
         end else begin
            if (consume)
               head_pc_reg <= head_pc_reg + (head_compressed ? XLEN'(2) : XLEN'(4));
            if (ack_take) begin
               fetch_addr_reg <= fetch_addr_reg + XLEN'(4);
               skip_low_reg   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: directed test of fetch_aligner with a simple memory model
// whose ack latency is adjustable.
module tb_fetch_aligner;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;

   int vectors;
   int miscompares;

   logic [31:0] mem_words [0:255];
   int          mem_lat;
   int          wait_cnt;

   fetch_aligner #(.XLEN(32), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: acks once the request has been held for mem_lat cycles.
   always @(posedge clk) begin
      if (rst || !imem_req || imem_ack)
         wait_cnt <= 0;
      else
         wait_cnt <= wait_cnt + 1;
   end
   assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
   assign imem_rdata = imem_ack ? mem_words[imem_addr[9:2]] : 32'hDEAD_BEEF;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      bit found;
      bit saw_new;
      logic [31:0] held_out;

      vectors     = 0;
      miscompares = 0;
      mem_lat     = 0;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem_words[i] = 32'h0000_0013;
      mem_words[0] = 32'h0010_0093;
      mem_words[1] = 32'h0020_0113;

      @(negedge clk);
      step();
      chk("reset_req", {31'h0, imem_req}, 32'h0);
      chk("reset_addr", imem_addr, 32'h0);
      chk("reset_valid", {31'h0, instr_valid}, 32'h0);
      chk("reset_out", instr_out, 32'h0);
      chk("reset_pc", instr_pc, 32'h0);

      // Straight-line 32-bit code.
      rst = 1'b0;
      step();
      chk("t1_req_c1", {31'h0, imem_req}, 32'h1);
      chk("t1_valid_c1", {31'h0, instr_valid}, 32'h0);
      step();
      chk("t1_valid_c2", {31'h0, instr_valid}, 32'h1);
      chk("t1_out0", instr_out, 32'h0010_0093);
      chk("t1_pc0", instr_pc, 32'h0);
      step();
      chk("t1_gap_valid", {31'h0, instr_valid}, 32'h0);
      chk("t1_addr1", imem_addr, 32'h4);
      step();
      chk("t1_out1", instr_out, 32'h0020_0113);
      chk("t1_pc1", instr_pc, 32'h4);
      instr_ready = 1'b0;

      // Mixed RVC / 32-bit across a word boundary.
      rst = 1'b1;
      step();
      step();
      mem_words[0] = 32'h0093_4505;
      mem_words[1] = 32'h0000_0100;
      instr_ready  = 1'b1;
      rst          = 1'b0;
      step();
      step();
      chk("t2_out0", instr_out, 32'h0000_4505);
      chk("t2_pc0", instr_pc, 32'h0);
      step();
      chk("t2_partial_valid", {31'h0, instr_valid}, 32'h0);
      step();
      chk("t2_out1", instr_out, 32'h0100_0093);
      chk("t2_pc1", instr_pc, 32'h2);

      // Backpressure: output holds, no new requests with a full buffer.
      instr_ready = 1'b0;
      held_out    = instr_out;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_out_%0d", i), instr_out, held_out);
         chk($sformatf("bp_pc_%0d", i), instr_pc, 32'h2);
         chk($sformatf("bp_req_%0d", i), {31'h0, imem_req}, 32'h0);
      end
      instr_ready = 1'b1;
      step();
      chk("bp_resume_valid", {31'h0, instr_valid}, 32'h1);
      chk("bp_resume_out", instr_out, 32'h0);
      chk("bp_resume_pc", instr_pc, 32'h6);
      chk("bp_resume_addr", imem_addr, 32'h8);
      instr_ready = 1'b0;
      step();
      step();

      // Redirect to a halfword address.
      mem_words[64]  = 32'h4585_AAAA;
      mem_words[112] = 32'h0070_0393;
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
      chk("rd_addr", imem_addr, 32'h100);
      chk("rd_req", {31'h0, imem_req}, 32'h1);
      chk("rd_empty", {31'h0, instr_valid}, 32'h0);
      chk("rd_pc_early", instr_pc, 32'h102);
      step();
      chk("rd_out", instr_out, 32'h0000_4585);
      chk("rd_pc", instr_pc, 32'h102);
      chk("rd_next_addr", imem_addr, 32'h104);
      chk("rd_ack_live", {31'h0, imem_ack}, 32'h1);

      // Consume, ack and redirect in the same cycle: redirect wins.
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h1C0;
      step();
      redirect    = 1'b0;
      instr_ready = 1'b0;
      chk("cr_empty", {31'h0, instr_valid}, 32'h0);
      chk("cr_pc", instr_pc, 32'h1C0);
      chk("cr_req", {31'h0, imem_req}, 32'h1);
      chk("cr_addr", imem_addr, 32'h1C0);
      step();
      chk("cr_out", instr_out, 32'h0070_0393);
      chk("cr_out_pc", instr_pc, 32'h1C0);

      // Redirects while a request is pending, including one during FLUSH.
      mem_words[16] = 32'h1111_1111;
      mem_words[24] = 32'h3333_3333;
      mem_words[32] = 32'h0050_0293;
      mem_lat     = 3;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      chk("pend_addr0", imem_addr, 32'h40);
      chk("pend_pc0", instr_pc, 32'h40);
      redirect_pc = 32'h60;
      step();
      chk("pend_addr_hold1", imem_addr, 32'h40);
      chk("pend_pc1", instr_pc, 32'h60);
      redirect_pc = 32'h80;
      step();
      chk("pend_addr_hold2", imem_addr, 32'h40);
      chk("pend_req_hold", {31'h0, imem_req}, 32'h1);
      chk("pend_pc2", instr_pc, 32'h80);
      redirect    = 1'b0;
      instr_ready = 1'b1;
      found   = 1'b0;
      saw_new = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (imem_req && imem_addr == 32'h80) saw_new = 1'b1;
         if (instr_valid) begin
            found = 1'b1;
            break;
         end
      end
      chk("pend_valid_timeout", {31'h0, found}, 32'h1);
      chk("pend_new_addr", {31'h0, saw_new}, 32'h1);
      chk("pend_out", instr_out, 32'h0050_0293);
      chk("pend_out_pc", instr_pc, 32'h80);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
